// File: rtl/rect_fill_plotter_pkg.sv
// Shared types and resolution constants for the rectangle fill plotter.
package rect_fill_plotter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StDraw = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned XMaxLo = 160;
    localparam int unsigned YMaxLo = 120;
    localparam int unsigned XMaxHi = 320;
    localparam int unsigned YMaxHi = 240;

endpackage

// File: rtl/rect_fill_plotter_if.sv
// Command and pixel-write bundle between a command source and the plotter.
interface rect_fill_plotter_if #(
    parameter int unsigned X_W = 8,
    parameter int unsigned Y_W = 7,
    parameter int unsigned CW  = 9
);
    logic           go;
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [X_W-1:0] w;
    logic [Y_W-1:0] h;
    logic [CW-1:0]  colour_in;
    logic           ready;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [CW-1:0]  colour;
    logic           plot;
    logic           done;

    modport master (
        output go, x0, y0, w, h, colour_in,
        input  ready, x, y, colour, plot, done
    );

    modport slave (
        input  go, x0, y0, w, h, colour_in,
        output ready, x, y, colour, plot, done
    );
endinterface

// File: rtl/rect_fill_plotter_clipper.sv
// Clips a rectangle size against the screen edge; one extra bit keeps the sums from wrapping.
module rect_fill_plotter_clipper #(
    parameter int unsigned XMAX = 160,
    parameter int unsigned YMAX = 120,
    parameter int unsigned X_W  = 8,
    parameter int unsigned Y_W  = 7
) (
    input  logic [X_W-1:0] x0_i,
    input  logic [Y_W-1:0] y0_i,
    input  logic [X_W-1:0] w_i,
    input  logic [Y_W-1:0] h_i,
    output logic [X_W:0]   we_o,
    output logic [Y_W:0]   he_o,
    output logic           empty_o
);
    localparam logic [X_W:0] XLim = XMAX[X_W:0];
    localparam logic [Y_W:0] YLim = YMAX[Y_W:0];

    logic [X_W:0] x0_ext, w_ext, x_room;
    logic [Y_W:0] y0_ext, h_ext, y_room;

    always_comb begin
        x0_ext = {1'b0, x0_i};
        w_ext  = {1'b0, w_i};
        y0_ext = {1'b0, y0_i};
        h_ext  = {1'b0, h_i};
        x_room = XLim - x0_ext;
        y_room = YLim - y0_ext;
        we_o   = (x0_ext >= XLim) ? '0 : ((w_ext < x_room) ? w_ext : x_room);
        he_o   = (y0_ext >= YLim) ? '0 : ((h_ext < y_room) ? h_ext : y_room);
        empty_o = (we_o == '0) || (he_o == '0);
    end
endmodule

// File: rtl/rect_fill_plotter.sv
// Rectangle fill engine: accepts one command, then emits one raster-order pixel write per clock.
module rect_fill_plotter
    import rect_fill_plotter_pkg::*;
#(
    parameter string       RESOLUTION              = "160x120",
    parameter int unsigned BITS_PER_COLOUR_CHANNEL = 3
) (
    input logic               clock,
    input logic               resetn,
    rect_fill_plotter_if.slave bus
);
    localparam bit          HiRes = (RESOLUTION == "320x240");
    localparam int unsigned XMAX  = HiRes ? XMaxHi : XMaxLo;
    localparam int unsigned YMAX  = HiRes ? YMaxHi : YMaxLo;
    localparam int unsigned X_W   = HiRes ? 9 : 8;
    localparam int unsigned Y_W   = HiRes ? 8 : 7;
    localparam int unsigned CW    = 3 * BITS_PER_COLOUR_CHANNEL;

    state_e         state_q, state_d;
    logic [X_W-1:0] x0_q, x0_d, x_q, x_d;
    logic [Y_W-1:0] y0_q, y0_d, y_q, y_d;
    logic [X_W:0]   we_q, we_d, cx_q, cx_d;
    logic [Y_W:0]   he_q, he_d, cy_q, cy_d;
    logic [CW-1:0]  colour_q, colour_d;
    logic           plot_q, plot_d, done_q, done_d;

    logic [X_W:0] we;
    logic [Y_W:0] he;
    logic         empty, row_end, col_end;

    rect_fill_plotter_clipper #(
        .XMAX(XMAX),
        .YMAX(YMAX),
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_clipper (
        .x0_i   (bus.x0),
        .y0_i   (bus.y0),
        .w_i    (bus.w),
        .h_i    (bus.h),
        .we_o   (we),
        .he_o   (he),
        .empty_o(empty)
    );

    assign row_end = (cx_q == we_q - 1'b1);
    assign col_end = (cy_q == he_q - 1'b1);

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        we_d     = we_q;
        he_d     = he_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.go) begin
                    x0_d = bus.x0;
                    y0_d = bus.y0;
                    we_d = we;
                    he_d = he;
                    cx_d = '0;
                    cy_d = '0;
                    if (empty) begin
                        // Nothing to draw: outputs keep their previous pixel.
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = StDraw;
                        x_d      = bus.x0;
                        y_d      = bus.y0;
                        colour_d = bus.colour_in;
                        plot_d   = 1'b1;
                    end
                end
            end
            StDraw: begin
                if (row_end && col_end) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end else if (row_end) begin
                    cx_d   = '0;
                    cy_d   = cy_q + 1'b1;
                    x_d    = x0_q;
                    y_d    = y_q + 1'b1;
                    plot_d = 1'b1;
                end else begin
                    cx_d   = cx_q + 1'b1;
                    x_d    = x_q + 1'b1;
                    plot_d = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= StIdle;
            x0_q     <= '0;
            y0_q     <= '0;
            we_q     <= '0;
            he_q     <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            we_q     <= we_d;
            he_q     <= he_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            done_q   <= done_d;
        end
    end

    // Idle is reported while reset is held so a source never sees a stale busy.
    assign bus.ready  = (state_q == StIdle) || !resetn;
    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_rect_fill_plotter.sv
// Directed bench for rect_fill_plotter at 160x120 with a coverage scoreboard for the full clear.
module tb_rect_fill_plotter;
    logic clk;
    logic resetn;
    int   errors;
    int   checks;
    bit   sb_en;
    int unsigned hits [0:19199];

    rect_fill_plotter_if #(.X_W(8), .Y_W(7), .CW(9)) bus ();

    rect_fill_plotter #(
        .RESOLUTION             ("160x120"),
        .BITS_PER_COLOUR_CHANNEL(3)
    ) dut (
        .clock (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sb_en && bus.plot) begin
            hits[32'(bus.y) * 160 + 32'(bus.x)] <= hits[32'(bus.y) * 160 + 32'(bus.x)] + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a command, then checks every expected pixel, done timing and ready recovery.
    task automatic run_cmd(input int x0, input int y0, input int w, input int h, input int col,
                           input int ew, input int eh, input int poke_at, input int abort_at);
        int idx;
        @(negedge clk);
        check_eq("ready_before_go", 32'(bus.ready), 1);
        bus.go        = 1'b1;
        bus.x0        = 8'(x0);
        bus.y0        = 7'(y0);
        bus.w         = 8'(w);
        bus.h         = 7'(h);
        bus.colour_in = 9'(col);
        tick();
        bus.go = 1'b0;
        idx = 0;
        for (int j = 0; j < eh; j++) begin
            for (int i = 0; i < ew; i++) begin
                check_eq("plot", 32'(bus.plot), 1);
                check_eq("x", 32'(bus.x), x0 + i);
                check_eq("y", 32'(bus.y), y0 + j);
                check_eq("colour", 32'(bus.colour), col);
                check_eq("ready_busy", 32'(bus.ready), 0);
                if (idx == abort_at) begin
                    resetn = 1'b0;
                    tick();
                    check_eq("rst_plot", 32'(bus.plot), 0);
                    check_eq("rst_x", 32'(bus.x), 0);
                    check_eq("rst_y", 32'(bus.y), 0);
                    check_eq("rst_done", 32'(bus.done), 0);
                    check_eq("rst_ready", 32'(bus.ready), 1);
                    resetn = 1'b1;
                    tick();
                    check_eq("post_rst_done", 32'(bus.done), 0);
                    check_eq("post_rst_ready", 32'(bus.ready), 1);
                    check_eq("post_rst_plot", 32'(bus.plot), 0);
                    return;
                end
                if (idx == poke_at) begin
                    bus.go        = 1'b1;
                    bus.x0        = 8'd0;
                    bus.y0        = 7'd0;
                    bus.w         = 8'd50;
                    bus.h         = 7'd50;
                    bus.colour_in = 9'h00F;
                end else begin
                    bus.go = 1'b0;
                end
                tick();
                idx++;
            end
        end
        bus.go = 1'b0;
        check_eq("done_pulse", 32'(bus.done), 1);
        check_eq("done_plot", 32'(bus.plot), 0);
        check_eq("done_ready", 32'(bus.ready), 0);
        tick();
        check_eq("ready_after", 32'(bus.ready), 1);
        check_eq("done_single", 32'(bus.done), 0);
        check_eq("idle_plot", 32'(bus.plot), 0);
    endtask

    initial begin
        int bad;
        errors        = 0;
        checks        = 0;
        sb_en         = 1'b0;
        resetn        = 1'b0;
        bus.go        = 1'b0;
        bus.x0        = '0;
        bus.y0        = '0;
        bus.w         = '0;
        bus.h         = '0;
        bus.colour_in = '0;
        tick();
        tick();
        check_eq("reset_ready", 32'(bus.ready), 1);
        check_eq("reset_plot", 32'(bus.plot), 0);
        check_eq("reset_done", 32'(bus.done), 0);
        check_eq("reset_x", 32'(bus.x), 0);
        check_eq("reset_y", 32'(bus.y), 0);
        check_eq("reset_colour", 32'(bus.colour), 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check_eq("ready_out_of_reset", 32'(bus.ready), 1);

        // Basic 3x2 box.
        run_cmd(5, 7, 3, 2, 'h1C0, 3, 2, -1, -1);
        // Clipped at the bottom-right corner.
        run_cmd(158, 118, 10, 10, 'h0AA, 2, 2, -1, -1);
        // Zero-area commands: off-screen origin and zero width.
        run_cmd(160, 0, 5, 5, 'h111, 0, 0, -1, -1);
        run_cmd(3, 3, 0, 4, 'h122, 0, 0, -1, -1);
        // A go pulsed mid-draw must not disturb the running command.
        run_cmd(20, 30, 4, 3, 'h03C, 4, 3, 5, -1);
        // Reset in the middle of a draw.
        run_cmd(10, 10, 8, 8, 'h155, 8, 8, -1, 20);
        run_cmd(1, 2, 2, 1, 'h1FF, 2, 1, -1, -1);

        // go held high through DONE is taken in the very next idle cycle.
        @(negedge clk);
        bus.go = 1'b1;
        bus.x0 = 8'd160;
        bus.y0 = 7'd0;
        bus.w  = 8'd5;
        bus.h  = 7'd5;
        tick();
        check_eq("held_done1", 32'(bus.done), 1);
        check_eq("held_ready1", 32'(bus.ready), 0);
        tick();
        check_eq("held_idle", 32'(bus.ready), 1);
        check_eq("held_gap", 32'(bus.done), 0);
        tick();
        check_eq("held_done2", 32'(bus.done), 1);
        bus.go = 1'b0;
        tick();
        check_eq("held_ready2", 32'(bus.ready), 1);

        // Full-screen clear with address coverage.
        sb_en = 1'b1;
        run_cmd(0, 0, 160, 120, 'h049, 160, 120, -1, -1);
        @(negedge clk);
        sb_en = 1'b0;
        bad = 0;
        for (int k = 0; k < 19200; k++) begin
            if (hits[k] != 1) bad++;
        end
        check_eq("clear_coverage", 32'(bad), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
